// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// ------------
// Buffered 8N1 UART transmitter. Bytes written on DATA_IN are queued in a
// circular FIFO and serialized LSB first onto UART_TX (start bit 0, eight
// data bits, stop bit 1). Back-to-back frames are sent with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2), default `T
//   DEPTH         FIFO entries (power of two, >= 2), default 16
// Ports:
//   CLK         system clock, all logic on posedge
//   INITIALIZE  synchronous active-high reset
//   DATA_IN     byte to transmit
//   WE          write strobe, accepted when WE && !FULL
//   FULL        FIFO holds DEPTH entries
//   EMPTY       FIFO holds no entries
//   BUSY        FIFO non-empty or a frame in flight (registered)
//   OVERRUN     sticky, set by a write while FULL
//   UART_TX     serial line, idle high (registered)

`ifndef T
`define T 16
`endif

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = `T,
  parameter int DEPTH        = 16
) (
  input  logic       CLK,
  input  logic       INITIALIZE,
  input  logic [7:0] DATA_IN,
  input  logic       WE,
  output logic       FULL,
  output logic       EMPTY,
  output logic       BUSY,
  output logic       OVERRUN,
  output logic       UART_TX
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity: XOR of the data bits.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            bit_end_s;
  logic [7:0]      head_s;

  assign full_s    = (count_q == (AW+1)'(DEPTH));
  assign empty_s   = (count_q == {(AW+1){1'b0}});
  // A write while FULL is dropped; only OVERRUN records it.
  assign push_s    = WE && !full_s;
  assign bit_end_s = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign head_s    = mem_q[rd_ptr_q];

  assign FULL    = full_s;
  assign EMPTY   = empty_s;
  assign BUSY    = busy_q;
  assign OVERRUN = ovr_q;
  assign UART_TX = tx_q;

  // Transmit FSM next state; the line level is derived from the current
  // state so it appears on UART_TX one cycle after the state is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = {CW{1'b0}};
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(head_s);
`endif
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end_s) begin
          cnt_d = {CW{1'b0}};
          // Chain straight into the next frame to avoid an idle gap.
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(head_s);
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers, occupancy, status flags.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    ovr_d  = ovr_q | (WE & full_s);
    busy_d = (state_q != S_IDLE) || !empty_s;
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s && !INITIALIZE) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule
